data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Multi-cycle data-memory responder serving the processor MEM stage's load/store requests.
- Holds a word-addressed 32-bit memory array and answers each request after a fixed LATENCY.
- Asserts stall so the pipeline freezes until the access completes.
- Accepts the pipeline flush to abort an access that has not yet committed.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W words of 32 bits.
- LATENCY, 3, stall cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  access request from MEM stage; held stable by requester while stall=1.
- req_write  input  1  1=store, 0=load; qualified by req_valid.
- req_addr  input  32  ALU result used as word address; only bits [ADDR_W-1:0] used.
- req_wdata  input  32  store data (register RdRq value).
- flush  input  1  pipeline flush; aborts an uncommitted access.
- stall  output  1  freeze pipeline; combinational from state and req_valid.
- rdata  output  32  load data; valid when rdata_valid=1, held afterwards until next load completes.
- rdata_valid  output  1  one-cycle pulse marking completion of a load.
- busy  output  1  registered; 1 in WAIT or RESP.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0, rdata=0, rdata_valid=0, busy=0, all array words=0.
  - Reset mid-access discards the access; no array write occurs.
- State IDLE:
  - stall = req_valid & ~flush.
  - If req_valid & ~flush: latch addr[ADDR_W-1:0], req_write and wdata; cnt <= LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
  - If flush=1 or req_valid=0: stay IDLE, no access.
- State WAIT:
  - stall=1.
  - If flush=1: return to IDLE, no write, stall drops to 0 that same cycle (combinational on flush).
  - Else if cnt==1: go to RESP.
  - Else cnt <= cnt-1.
- Commit:
  - Occurs on the edge that enters RESP.
  - Store: array[addr] <= wdata.
  - Load: rdata <= array[addr].
- State RESP:
  - stall=0; rdata_valid=1 for a load, 0 for a store.
  - flush is ignored because the access is already committed.
  - Next state is always IDLE, even if req_valid is still high: the requester advances on this edge.
- Timing:
  - A request accepted in cycle T has stall=1 in cycles T..T+LATENCY-1 and RESP in cycle T+LATENCY.
  - Per-access occupancy is LATENCY+1 cycles.
  - Back-to-back requests: the earliest next acceptance is cycle T+LATENCY+1.
- Read-after-write: a load to an address stored by the previous access returns the new data.
- Address wrap: bits above ADDR_W-1 are ignored, so 0x100 aliases 0x000 when ADDR_W=8.
- rdata changes only when a load commits or on reset.

Test Plan:
- Reset then idle with req_valid=0:
  - stall=0, rdata=0, rdata_valid=0, busy=0 for 10 cycles.
- Store then load, LATENCY=3:
  - Store addr 0x05, data 0xDEADBEEF gives stall=1 for exactly 3 cycles, then RESP with rdata_valid=0.
  - Load addr 0x05 gives stall for 3 cycles, then rdata=0xDEADBEEF with rdata_valid=1 for 1 cycle.
- Flush in the 2nd WAIT cycle of a store (addr 0x07, data 0x12345678):
  - stall drops that cycle and state returns to IDLE.
  - A later load of 0x07 returns 0x00000000.
- Flush asserted in RESP of a store (addr 0x09, data 0xA5A5A5A5):
  - The write is retained; a later load of 0x09 returns 0xA5A5A5A5.
- Address aliasing, ADDR_W=8:
  - Store addr 0x00000103, data 0x11112222.
  - A load of addr 0x03 returns 0x11112222.
- LATENCY=1, back-to-back loads with req_valid held high:
  - Each load gives stall=1 for 1 cycle, then RESP; the next acceptance follows in the next cycle.
  - Exactly two rdata_valid pulses occur, 2 cycles apart.
- Synchronous reset asserted during WAIT of a store to 0x0A:
  - state=IDLE and stall=0 the next cycle.
  - A load of 0x0A returns 0.

Source files
------------

// File: rtl/data_mem_resp_if.sv
// ---------------------------------------------------------------------------
// data_mem_resp_if : MEM-stage request/response bundle for data_mem_resp
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface data_mem_resp_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush,
    input  stall, rdata, rdata_valid, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush,
    output stall, rdata, rdata_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_resp.sv
// ---------------------------------------------------------------------------
// data_mem_resp : fixed-latency word-addressed data memory with pipeline stall
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_resp #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  wire              clk,
  input  wire              rst,
  data_mem_resp_if.slave   bus
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q;
  logic              busy_q;

  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic              commit_write;
  logic [31:0]       commit_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W];

  assign accept = (state == IDLE) && bus.req_valid && !bus.flush;
  assign commit = (state_next == RESP) && (state != RESP);

  // With LATENCY==1 the commit edge is the acceptance edge, so take the live request.
  assign commit_addr  = (state == IDLE) ? bus.req_addr[ADDR_W-1:0] : addr_q;
  assign commit_write = (state == IDLE) ? bus.req_write            : write_q;
  assign commit_wdata = (state == IDLE) ? bus.req_wdata            : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.stall       = 1'b0;
    bus.rdata_valid = 1'b0;
    case (state)
      IDLE:    bus.stall = bus.req_valid && !bus.flush;
      WAIT:    bus.stall = !bus.flush;
      RESP:    bus.rdata_valid = !write_q;
      default: bus.stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_next == WAIT) || (state_next == RESP);
      if (accept) begin
        cnt     <= CNT_INIT;
        addr_q  <= bus.req_addr[ADDR_W-1:0];
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
      rdata_q <= 32'd0;
    end else if (commit) begin
      if (commit_write) begin
        mem[commit_addr] <= commit_wdata;
      end else begin
        rdata_q <= mem[commit_addr];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_data_mem_resp : directed bench for data_mem_resp (LATENCY=3 and LATENCY=1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_resp_if i3 ();
  data_mem_resp_if i1 ();

  data_mem_resp #(.ADDR_W(8), .LATENCY(3)) m3 (.clk(clk), .rst(rst), .bus(i3));
  data_mem_resp #(.ADDR_W(8), .LATENCY(1)) m1 (.clk(clk), .rst(rst), .bus(i1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full access on the LATENCY=3 instance, optionally flushing during RESP.
  task automatic access3(input string tag, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input bit flush_in_resp);
    int n;
    i3.req_valid = 1'b1;
    i3.req_write = wr;
    i3.req_addr  = a;
    i3.req_wdata = d;
    #1;
    n = 0;
    while (i3.stall === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'd3);
    chk({tag, " resp_valid"}, {31'd0, i3.rdata_valid}, {31'd0, !wr});
    chk({tag, " resp_busy"}, {31'd0, i3.busy}, 32'd1);
    if (!wr) chk({tag, " rdata"}, i3.rdata, exp_rd);
    i3.flush     = flush_in_resp;
    i3.req_valid = 1'b0;
    tick();
    i3.flush = 1'b0;
    #1;
    chk({tag, " after_valid"}, {31'd0, i3.rdata_valid}, 32'd0);
    chk({tag, " after_busy"}, {31'd0, i3.busy}, 32'd0);
    chk({tag, " after_stall"}, {31'd0, i3.stall}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first_pulse;
    int last_pulse;

    i3.req_valid = 0; i3.req_write = 0; i3.req_addr = 0; i3.req_wdata = 0; i3.flush = 0;
    i1.req_valid = 0; i1.req_write = 0; i1.req_addr = 0; i1.req_wdata = 0; i1.flush = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle stall", {31'd0, i3.stall}, 32'd0);
      chk("idle rdata", i3.rdata, 32'd0);
      chk("idle rvalid", {31'd0, i3.rdata_valid}, 32'd0);
      chk("idle busy", {31'd0, i3.busy}, 32'd0);
    end

    // Store then read-after-write load.
    access3("st05", 1'b1, 32'h05, 32'hDEADBEEF, 32'h0, 1'b0);
    access3("ld05", 1'b0, 32'h05, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("ld05 rdata_held", i3.rdata, 32'hDEADBEEF);

    // Flush in the second WAIT cycle of a store to 0x07.
    i3.req_valid = 1'b1; i3.req_write = 1'b1; i3.req_addr = 32'h07; i3.req_wdata = 32'h12345678;
    #1;
    chk("fl07 accept_stall", {31'd0, i3.stall}, 32'd1);
    tick();
    chk("fl07 wait1_stall", {31'd0, i3.stall}, 32'd1);
    tick();
    chk("fl07 wait2_stall", {31'd0, i3.stall}, 32'd1);
    i3.flush = 1'b1;
    i3.req_valid = 1'b0;
    #1;
    chk("fl07 flush_stall", {31'd0, i3.stall}, 32'd0);
    tick();
    i3.flush = 1'b0;
    #1;
    chk("fl07 idle_busy", {31'd0, i3.busy}, 32'd0);
    chk("fl07 idle_stall", {31'd0, i3.stall}, 32'd0);
    access3("ld07", 1'b0, 32'h07, 32'h0, 32'h00000000, 1'b0);

    // Flush in RESP cannot undo a committed store.
    access3("st09", 1'b1, 32'h09, 32'hA5A5A5A5, 32'h0, 1'b1);
    access3("ld09", 1'b0, 32'h09, 32'h0, 32'hA5A5A5A5, 1'b0);

    // High address bits ignored.
    access3("st103", 1'b1, 32'h00000103, 32'h11112222, 32'h0, 1'b0);
    access3("ld03", 1'b0, 32'h03, 32'h0, 32'h11112222, 1'b0);
    chk("ld03 rdata_held", i3.rdata, 32'h11112222);

    // LATENCY=1: seed two words, then back-to-back loads with req_valid held.
    for (int k = 0; k < 2; k++) begin
      i1.req_valid = 1'b1; i1.req_write = 1'b1;
      i1.req_addr = 32'h20 + 32'(k); i1.req_wdata = (k == 0) ? 32'h0BADF00D : 32'h600DCAFE;
      #1;
      chk("l1 st stall", {31'd0, i1.stall}, 32'd1);
      tick();
      chk("l1 st resp_stall", {31'd0, i1.stall}, 32'd0);
      chk("l1 st resp_valid", {31'd0, i1.rdata_valid}, 32'd0);
      i1.req_valid = 1'b0;
      tick();
    end
    i1.req_valid = 1'b1; i1.req_write = 1'b0; i1.req_addr = 32'h20;
    pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0 || c == 2) chk("l1 ld accept_stall", {31'd0, i1.stall}, 32'd1);
      if (c == 1) chk("l1 ld rdata0", i1.rdata, 32'h0BADF00D);
      if (c == 3) chk("l1 ld rdata1", i1.rdata, 32'h600DCAFE);
      if (i1.rdata_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
        last_pulse = c;
      end
      if (c == 1) i1.req_addr = 32'h21;
      if (c == 3) i1.req_valid = 1'b0;
      tick();
    end
    chk("l1 pulse_count", 32'(pulses), 32'd2);
    chk("l1 pulse_spacing", 32'(last_pulse - first_pulse), 32'd2);
    chk("l1 first_pulse_cycle", 32'(first_pulse), 32'd1);

    // Reset during WAIT of a store to 0x0A.
    i3.req_valid = 1'b1; i3.req_write = 1'b1; i3.req_addr = 32'h0A; i3.req_wdata = 32'hCAFEF00D;
    tick();
    chk("rst0a wait_stall", {31'd0, i3.stall}, 32'd1);
    rst = 1'b1;
    i3.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst0a stall", {31'd0, i3.stall}, 32'd0);
    chk("rst0a busy", {31'd0, i3.busy}, 32'd0);
    chk("rst0a rdata", i3.rdata, 32'd0);
    access3("ld0a", 1'b0, 32'h0A, 32'h0, 32'h00000000, 1'b0);
    access3("ld05r", 1'b0, 32'h05, 32'h0, 32'h00000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
